multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Multi-cycle instruction sequencer for the KGPminiRISC core.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and issues the per-cycle enable strobes for the PC, IR, register file and the shared instruction/data memory port.
- Sits beside the combinational opcode decoder: the decoder supplies the datapath mux selects, and this block decides when each one takes effect.
- Also handles the memory ready handshake, memory timeout, illegal opcodes, a stop request and the retired-instruction count.

Parameters:
- MEM_TIMEOUT, 16: maximum wait cycles for mem_ready before a bus error; must be >=1.
- CNT_W, 32: width of instr_count.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin execution from IDLE; level-sampled
- stop  input  1  request return to IDLE at the next retirement boundary
- opcode  input  6  opcode field of the IR; valid from DECODE onward
- mem_ready  input  1  memory completes the current request this cycle
- branch_taken  input  1  condition result for a conditional branch; valid in EXEC
- mem_req  output  1  memory request active
- mem_we  output  1  write request; meaningful only with mem_req
- addr_sel  output  1  memory address source: 0 = PC, 1 = ALU result
- ir_write  output  1  load IR from memory read data
- pc_write  output  1  update PC
- pc_src  output  2  PC source: 00 = PC+4, 01 = register (br), 10 = PC-relative target
- reg_write  output  1  register file write enable
- busy  output  1  high in every state except IDLE and HALT
- halted  output  1  sticky; high in HALT
- illegal  output  1  sticky; HALT was caused by an undefined opcode
- bus_err  output  1  sticky; HALT was caused by a memory timeout
- instr_count  output  CNT_W  retired-instruction counter

Behaviour:
- Reset: asynchronous and immediate, including mid-instruction or mid-memory-request.
  - State goes to IDLE, all outputs 0, instr_count 0, wait counter 0.
- Opcode classes:
  - ALU: 000000, 000001
  - LW: 000010
  - SW: 000011
  - BR: 000100
  - COND: 000101, 000110, 000111, 001010, 001011
  - JMP: 001000
  - BL: 001001
  - Any other value is illegal.
- IDLE: all strobes 0. Go to FETCH when start=1.
- FETCH: mem_req=1, addr_sel=0, mem_we=0.
  - In the cycle mem_ready=1: ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
  - Otherwise the wait counter increments. If MEM_TIMEOUT consecutive cycles pass without ready, set bus_err=1 and go to HALT; no strobes fire in that cycle.
- DECODE: one cycle, no strobes.
  - Illegal opcode: illegal=1, go to HALT.
  - Otherwise go to EXEC.
- EXEC: one cycle.
  - ALU: go to WB.
  - LW/SW: go to MEM.
  - BR: pc_write=1, pc_src=01; retire.
  - JMP: pc_write=1, pc_src=10; retire.
  - BL: pc_write=1, pc_src=10, reg_write=1 (link); retire.
  - COND: pc_write=branch_taken, pc_src=10; retire whether or not the branch is taken.
- MEM: mem_req=1, addr_sel=1, mem_we=1 only for SW.
  - Wait-counter and timeout rules are identical to FETCH.
  - On mem_ready: LW goes to WB; SW retires.
- WB: reg_write=1 for one cycle; retire.
- Retire:
  - instr_count increments by 1 and wraps modulo 2^CNT_W.
  - Next state is IDLE if stop=1 in the retiring cycle, else FETCH.
- Wait counter: cleared on entry to FETCH or MEM and on every mem_ready.
- Minimum cycles per instruction (zero wait states):
  - ALU 4
  - LW 5
  - SW 4
  - branch classes 3
- Strobes are single-cycle pulses. pc_write and ir_write never assert outside the cycles listed above.
- start asserted while busy is ignored.
- stop asserted outside a retirement cycle has no effect; stop is not latched.
- HALT:
  - All strobes 0, halted=1, busy=0.
  - Exits only via reset; start is ignored.
  - illegal and bus_err are sticky until reset.
- Simultaneous stop and a timeout on the same cycle: timeout wins and the block goes to HALT.

Test Plan:
- Reset, start=1, opcode 000000, mem_ready always 1 → ir_write at cycle 1 after FETCH entry, reg_write exactly 3 cycles later, instr_count=1 after 4 cycles, FETCH re-entered.
- LW with mem_ready delayed 3 cycles in MEM → mem_req/addr_sel=1 held 4 cycles, mem_we=0, reg_write in the following cycle. SW → mem_we=1, no reg_write.
- bz (000110) with branch_taken=0 then 1 → pc_write=0 then pc_write=1 with pc_src=10; instr_count increments both times. bl (001001) → pc_write and reg_write in the same EXEC cycle.
- opcode 111111 → illegal=1, halted=1, busy=0 one cycle after DECODE; start pulses thereafter produce no strobes.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → bus_err=1 after 4 wait cycles, no ir_write. rst_n low mid-MEM → all outputs 0 immediately (asynchronous), state IDLE.
- CNT_W=4: retire 17 instructions → instr_count=1. stop=1 during WB → IDLE next cycle, busy=0.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer issuing PC/IR/regfile/memory strobes for KGPminiRISC.
// Strobes are combinational from state plus inputs; memory stalls are held by mem_ready, bounded by MEM_TIMEOUT.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LW, C_SW, C_BR, C_COND, C_JMP, C_BL, C_ILL
  } cls_t;

  state_t        state, state_nxt;
  cls_t          cls;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic          timeout;
  logic          retire;
  logic          set_ill;
  logic          set_be;

  always_comb begin
    case (opcode)
      6'b000000, 6'b000001:                         cls = C_ALU;
      6'b000010:                                    cls = C_LW;
      6'b000011:                                    cls = C_SW;
      6'b000100:                                    cls = C_BR;
      6'b000101, 6'b000110, 6'b000111,
      6'b001010, 6'b001011:                         cls = C_COND;
      6'b001000:                                    cls = C_JMP;
      6'b001001:                                    cls = C_BL;
      default:                                      cls = C_ILL;
    endcase
  end

  // Timeout fires on the MEM_TIMEOUT-th consecutive cycle without ready.
  assign timeout = (wait_cnt == WW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    reg_write = 1'b0;
    retire    = 1'b0;
    set_ill   = 1'b0;
    set_be    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FETCH;
          wait_nxt  = '0;
        end
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          wait_nxt  = '0;
          state_nxt = S_DECODE;
        end else if (timeout) begin
          set_be    = 1'b1;
          state_nxt = S_HALT;
        end else begin
          wait_nxt = wait_cnt + WW'(1);
        end
      end
      S_DECODE: begin
        if (cls == C_ILL) begin
          set_ill   = 1'b1;
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          C_ALU: state_nxt = S_WB;
          C_LW, C_SW: begin
            state_nxt = S_MEM;
            wait_nxt  = '0;
          end
          C_BR: begin
            pc_write = 1'b1;
            pc_src   = 2'b01;
            retire   = 1'b1;
          end
          C_JMP: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            retire   = 1'b1;
          end
          C_BL: begin
            pc_write  = 1'b1;
            pc_src    = 2'b10;
            reg_write = 1'b1;
            retire    = 1'b1;
          end
          C_COND: begin
            pc_write = branch_taken;
            pc_src   = 2'b10;
            retire   = 1'b1;
          end
          default: begin
            set_ill   = 1'b1;
            state_nxt = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (cls == C_SW);
        if (mem_ready) begin
          wait_nxt = '0;
          if (cls == C_SW) retire = 1'b1;
          else             state_nxt = S_WB;
        end else if (timeout) begin
          set_be    = 1'b1;
          state_nxt = S_HALT;
        end else begin
          wait_nxt = wait_cnt + WW'(1);
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      default: ;
    endcase
    if (retire) begin
      state_nxt = stop ? S_IDLE : S_FETCH;
      wait_nxt  = '0;
    end
  end

  assign busy   = (state != S_IDLE) && (state != S_HALT);
  assign halted = (state == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      instr_count <= '0;
      illegal     <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (retire)  instr_count <= instr_count + CNT_W'(1);
      if (set_ill) illegal     <= 1'b1;
      if (set_be)  bus_err     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-instruction expected cycle sequences built from the
// instruction rules, driven and compared cycle by cycle, plus literal spot checks.
module tb_multicycle_sequencer;

  localparam int TO = 4;
  localparam int CW = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;

  logic          clk = 1'b0;
  logic          rst_n, start, stop, mem_ready, branch_taken;
  logic [5:0]    opcode;
  logic          mem_req, mem_we, addr_sel, ir_write, pc_write, reg_write;
  logic          busy, halted, illegal, bus_err;
  logic [1:0]    pc_src;
  logic [CW-1:0] instr_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          start, stop, mem_ready, branch_taken;
    logic [5:0]    opcode;
    logic          e_req, e_we, e_asel, e_ir, e_pcw, e_rw, e_busy, e_halt, e_ill, e_be;
    logic [1:0]    e_pcs;
    logic [CW-1:0] e_cnt;
  } cyc_t;

  cyc_t gen_q[$];
  cyc_t exp_q[$];
  cyc_t ce;

  int            mode;
  logic [CW-1:0] m_cnt;
  logic          m_ill, m_be;

  logic [5:0] legal [12] = '{6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000101,
                             6'b000110, 6'b000111, 6'b001010, 6'b001011, 6'b001000, 6'b001001};

  multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .opcode(opcode),
    .mem_ready(mem_ready), .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .busy(busy), .halted(halted), .illegal(illegal),
    .bus_err(bus_err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // 0 ALU, 1 LW, 2 SW, 3 BR, 4 COND, 5 JMP, 6 BL, 7 illegal
  function automatic int cls(input logic [5:0] op);
    case (op)
      6'd0, 6'd1:                     return 0;
      6'd2:                           return 1;
      6'd3:                           return 2;
      6'd4:                           return 3;
      6'd5, 6'd6, 6'd7, 6'd10, 6'd11: return 4;
      6'd8:                           return 5;
      6'd9:                           return 6;
      default:                        return 7;
    endcase
  endfunction

  function automatic logic [15:0] dut_vec();
    return {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_write,
            busy, halted, illegal, bus_err, instr_count};
  endfunction

  function automatic logic [15:0] exp_vec(input cyc_t c);
    return {c.e_req, c.e_we, c.e_asel, c.e_ir, c.e_pcw, c.e_pcs, c.e_rw,
            c.e_busy, c.e_halt, c.e_ill, c.e_be, c.e_cnt};
  endfunction

  // Unused inputs are randomised so the DUT is shown to ignore them.
  function automatic cyc_t base();
    cyc_t c;
    c.start        = 1'($urandom_range(0, 1));
    c.stop         = 1'($urandom_range(0, 1));
    c.mem_ready    = 1'($urandom_range(0, 1));
    c.branch_taken = 1'($urandom_range(0, 1));
    c.opcode       = 6'($urandom);
    c.e_req = 0; c.e_we = 0; c.e_asel = 0; c.e_ir = 0; c.e_pcw = 0; c.e_rw = 0;
    c.e_pcs  = 2'b00;
    c.e_busy = (mode == M_RUN);
    c.e_halt = (mode == M_HALT);
    c.e_ill  = m_ill;
    c.e_be   = m_be;
    c.e_cnt  = m_cnt;
    return c;
  endfunction

  task automatic retire(input cyc_t c, input logic stp);
    c.stop = stp;
    gen_q.push_back(c);
    m_cnt = CW'(m_cnt + 1);
    if (stp) mode = M_IDLE;
  endtask

  task automatic gen_idle(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = base(); c.start = 1'b0; gen_q.push_back(c);
    end
    c = base(); c.start = 1'b1; gen_q.push_back(c);
    mode = M_RUN;
  endtask

  task automatic gen_halt(input int n);
    for (int i = 0; i < n; i++) gen_q.push_back(base());
  endtask

  task automatic gen_instr(input logic [5:0] op, input int fw, input int mw,
                           input logic bt, input logic stp);
    cyc_t c;
    int   k;
    k = cls(op);
    for (int i = 0; i < fw; i++) begin
      c = base(); c.mem_ready = 1'b0; c.e_req = 1'b1; gen_q.push_back(c);
      if (i == TO - 1) begin m_be = 1'b1; mode = M_HALT; return; end
    end
    c = base(); c.mem_ready = 1'b1; c.e_req = 1'b1; c.e_ir = 1'b1; c.e_pcw = 1'b1;
    gen_q.push_back(c);
    c = base(); c.opcode = op; gen_q.push_back(c);
    if (k == 7) begin m_ill = 1'b1; mode = M_HALT; return; end
    c = base(); c.opcode = op; c.branch_taken = bt;
    case (k)
      3: begin c.e_pcw = 1'b1; c.e_pcs = 2'b01; end
      4: begin c.e_pcw = bt;   c.e_pcs = 2'b10; end
      5: begin c.e_pcw = 1'b1; c.e_pcs = 2'b10; end
      6: begin c.e_pcw = 1'b1; c.e_pcs = 2'b10; c.e_rw = 1'b1; end
      default: ;
    endcase
    if (k >= 3) begin retire(c, stp); return; end
    gen_q.push_back(c);
    if (k == 1 || k == 2) begin
      for (int i = 0; i < mw; i++) begin
        c = base(); c.opcode = op; c.mem_ready = 1'b0;
        c.e_req = 1'b1; c.e_asel = 1'b1; c.e_we = (k == 2);
        gen_q.push_back(c);
        if (i == TO - 1) begin m_be = 1'b1; mode = M_HALT; return; end
      end
      c = base(); c.opcode = op; c.mem_ready = 1'b1;
      c.e_req = 1'b1; c.e_asel = 1'b1; c.e_we = (k == 2);
      if (k == 2) begin retire(c, stp); return; end
      gen_q.push_back(c);
    end
    c = base(); c.opcode = op; c.e_rw = 1'b1;
    retire(c, stp);
  endtask

  task automatic run_gen();
    cyc_t c;
    while (gen_q.size() > 0) begin
      c = gen_q.pop_front();
      @(posedge clk);
      #1;
      start = c.start; stop = c.stop; opcode = c.opcode;
      mem_ready = c.mem_ready; branch_taken = c.branch_taken;
      exp_q.push_back(c);
    end
    @(negedge clk);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic model_reset();
    mode = M_IDLE; m_cnt = '0; m_ill = 1'b0; m_be = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mem_ready = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] op;
    if ($urandom_range(0, 29) == 0) begin
      do op = 6'($urandom); while (cls(op) != 7);
    end else begin
      op = legal[$urandom_range(0, 11)];
    end
    return op;
  endfunction

  function automatic int rand_wait();
    return ($urandom_range(0, 19) == 0) ? TO : int'($urandom_range(0, 3));
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      checks++;
      if (dut_vec() !== exp_vec(ce)) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t op=%b actual=%b required=%b",
                 $time, opcode, dut_vec(), exp_vec(ce));
      end
    end
  end

  initial begin
    int n0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; opcode = '0;
    mem_ready = 1'b0; branch_taken = 1'b0;
    model_reset();
    #2;
    chk("reset_outputs", 32'(dut_vec()), 32'h0);
    #10 rst_n = 1'b1;

    // ALU zero-wait, stop at retire
    gen_idle(0);
    n0 = gen_q.size();
    gen_instr(6'b000000, 0, 0, 1'b0, 1'b1);
    chk("model_alu_cycles", 32'(gen_q.size() - n0), 4);
    run_gen(); settle();
    chk("alu_count", 32'(instr_count), 1);
    chk("alu_idle_busy", 32'(busy), 0);

    // LW with 3 wait states, SW, bz not-taken/taken, bl
    gen_idle(1);
    n0 = gen_q.size();
    gen_instr(6'b000010, 0, 3, 1'b0, 1'b0);
    chk("model_lw_cycles", 32'(gen_q.size() - n0), 8);
    n0 = gen_q.size();
    gen_instr(6'b000011, 0, 0, 1'b0, 1'b0);
    chk("model_sw_cycles", 32'(gen_q.size() - n0), 4);
    n0 = gen_q.size();
    gen_instr(6'b000110, 0, 0, 1'b0, 1'b0);
    gen_instr(6'b000110, 0, 0, 1'b1, 1'b0);
    gen_instr(6'b001001, 0, 0, 1'b0, 1'b1);
    chk("model_branch_cycles", 32'(gen_q.size() - n0), 9);
    run_gen(); settle();
    chk("mix_count", 32'(instr_count), 6);
    chk("mix_idle_busy", 32'(busy), 0);

    // illegal opcode
    gen_idle(0);
    gen_instr(6'b111111, 0, 0, 1'b0, 1'b0);
    gen_halt(5);
    run_gen(); settle();
    chk("illegal_flags", 32'({illegal, halted, busy, bus_err}), 32'b1100);
    do_reset();

    // fetch timeout
    gen_idle(0);
    n0 = gen_q.size();
    gen_instr(6'b000000, TO, 0, 1'b0, 1'b0);
    chk("model_timeout_cycles", 32'(gen_q.size() - n0), TO);
    gen_halt(3);
    run_gen(); settle();
    chk("timeout_flags", 32'({bus_err, illegal, halted, busy}), 32'b1010);
    do_reset();

    // async reset in the middle of a MEM wait
    gen_idle(0);
    gen_instr(6'b000010, 0, 2, 1'b0, 1'b0);
    void'(gen_q.pop_back());
    void'(gen_q.pop_back());
    run_gen();
    chk("mid_mem_req", 32'({mem_req, addr_sel, mem_we}), 32'b110);
    #1 rst_n = 1'b0;
    #1 chk("async_reset_outputs", 32'(dut_vec()), 32'h0);
    #1 rst_n = 1'b1;
    model_reset();
    mem_ready = 1'b0;

    // counter wrap: 17 retirements on a 4-bit counter
    gen_idle(0);
    for (int i = 0; i < 17; i++)
      gen_instr(6'b001000, 0, 0, 1'($urandom_range(0, 1)), (i == 16));
    run_gen(); settle();
    chk("count_wrap", 32'(instr_count), 1);

    // randomised traffic
    for (int n = 0; n < 250; n++) begin
      if (mode == M_IDLE) gen_idle($urandom_range(0, 2));
      if (mode == M_RUN)
        gen_instr(rand_op(), rand_wait(), rand_wait(), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0));
      if (mode == M_HALT) begin
        gen_halt(3);
        run_gen();
        do_reset();
      end else begin
        run_gen();
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
